// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states and default latencies.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3
  } md_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_calc.sv
// Combinational signed/unsigned product, quotient and remainder for mult/multu/div/divu.
module md_calc
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic        [31:0] div_bs;
  logic        [31:0] div_bu;
  logic               ovf;

  assign div_zero = (b == '0);
  assign ovf      = (a == 32'h8000_0000) && (b == '1);

  // Dividing by 1 instead of -1 on overflow yields quotient 0x80000000, remainder 0.
  assign div_bs = (div_zero || ovf) ? 32'd1 : b;
  assign div_bu = div_zero ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign quot_s = $signed(a) / $signed(div_bs);
  assign rem_s  = $signed(a) % $signed(div_bs);
  assign quot_u = a / div_bu;
  assign rem_u  = a % div_bu;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (md_op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV:   {hi_res, lo_res} = {rem_s, quot_s};
      MD_DIVU:  {hi_res, lo_res} = {rem_u, quot_u};
      default:  {hi_res, lo_res} = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; results are computed at start
// and held in pending registers until the busy countdown commits them.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hiWE,
  input  logic        loWE,
  input  logic        hisel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_E_o
);

  md_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      hi_nx, lo_nx;
  logic [31:0]      hi_pend, lo_pend, hi_pend_nx, lo_pend_nx;
  logic [31:0]      hi_res, lo_res;
  logic             div_zero;

  md_calc u_md_calc (
    .md_op    (md_op),
    .a        (rs_data),
    .b        (rt_data),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      hi_pend <= hi_pend_nx;
      lo_pend <= lo_pend_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi;
    lo_nx      = lo;
    hi_pend_nx = hi_pend;
    lo_pend_nx = lo_pend;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!md_op[2]) begin
            // Divide by zero commits the current HI/LO, leaving them unchanged.
            if (is_div(md_op) && div_zero) begin
              hi_pend_nx = hi;
              lo_pend_nx = lo;
            end else begin
              hi_pend_nx = hi_res;
              lo_pend_nx = lo_res;
            end
            cnt_nx   = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_nx = S_RUN;
          end
        end else begin
          if (hiWE) hi_nx = rs_data;
          if (loWE) lo_nx = rs_data;
        end
      end
      S_RUN: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_nx    = hi_pend;
          lo_nx    = lo_pend;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy   = (state == S_RUN);
  assign md_E_o = hisel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at issue, popped by a monitor at each commit.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, hiWE, loWE, hisel;
  logic [2:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo, md_E_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  logic        prev_busy = 1'b0;
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .hiWE(hiWE), .loWE(loWE),
    .hisel(hisel), .busy(busy), .hi(hi), .lo(lo), .md_E_o(md_E_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: products via 64-bit arithmetic, signed division via magnitudes and sign rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint sa, sb, ma, mb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {ch, cl};
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q = ma / mb;
        r = ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {ch, cl};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {ch, cl};
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_commit: got hi=%h lo=%h expected no commit", hi, lo);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_hi", hi, mon_e[63:32]);
          chk("commit_lo", lo, mon_e[31:0]);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_read();
    hisel = 1'b1; #1;
    chk("md_E_o_hi", md_E_o, m_hi);
    hisel = 1'b0; #1;
    chk("md_E_o_lo", md_E_o, m_lo);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit interfere);
    logic [31:0] oh, ol;
    logic [63:0] e;
    int n;
    wait_idle();
    @(posedge clk); #1;
    oh = m_hi;
    ol = m_lo;
    e = model(op, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    m_hi = e[63:32];
    m_lo = e[31:0];
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("hold_hi", hi, oh);
      chk("hold_lo", lo, ol);
      if (interfere && n == 3) begin
        start = 1'b1; md_op = MD_MULT; hiWE = 1'b1; loWE = 1'b1; rs_data = $urandom;
      end else if (interfere && n == 4) begin
        start = 1'b0; hiWE = 1'b0; loWE = 1'b0;
      end
    end
    chk("busy_len", 32'(n), (op == MD_DIV || op == MD_DIVU) ? 32'(DC) : 32'(MC));
    check_read();
  endtask

  task automatic mt(input bit wh, input bit wl, input logic [31:0] v);
    wait_idle();
    @(posedge clk); #1;
    hiWE = wh; loWE = wl; rs_data = v;
    @(posedge clk); #1;
    hiWE = 1'b0; loWE = 1'b0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
    check_read();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; hiWE = 1'b0; loWE = 1'b0; hisel = 1'b0;
    md_op = '0; rs_data = '0; rt_data = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_md_E_o", md_E_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("divu_hi", hi, 32'h0000_0001);
    chk("divu_lo", lo, 32'h7FFF_FFFC);

    mt(1'b1, 1'b0, 32'h1234_5678);
    mt(1'b0, 1'b1, 32'h9ABC_DEF0);
    run_op(MD_DIV, 32'd1234, 32'd0, 1'b0);
    chk("div0_hi", hi, 32'h1234_5678);
    chk("div0_lo", lo, 32'h9ABC_DEF0);
    mt(1'b1, 1'b1, 32'hCAFE_F00D);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_lo", lo, 32'h8000_0000);

    // Reserved op: start ignored, and the concurrent hiWE is ignored because start=1.
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd5; rs_data = $urandom; rt_data = $urandom; hiWE = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hiWE = 1'b0;
    @(negedge clk);
    chk("rsvd_busy", 32'(busy), 32'd0);
    chk("rsvd_hi", hi, m_hi);
    chk("rsvd_lo", lo, m_lo);

    // Abort a mult with reset in its third busy cycle.
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MULT; rs_data = 32'd5; rt_data = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("nocommit_busy", 32'(busy), 32'd0);
    chk("nocommit_hi", hi, 32'd0);
    chk("nocommit_lo", lo, 32'd0);

    run_op(MD_DIV, 32'd100, 32'd7, 1'b1);
    chk("interf_hi", hi, 32'd2);
    chk("interf_lo", lo, 32'd14);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) mt(1'($urandom), 1'b1, $urandom);
      run_op(op, a, b, 1'($urandom_range(0, 3) == 0));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Instantiated inside the Execute stage; fed by E-stage forwarded operands and by the E-stage Controller decode (md_op, start, hiWE, loWE, hisel).
- Result read back through md_E_o into the E/M pipeline register.
- busy and start go to the hazard/forward unit, which freezes the pipeline while a mult/div is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch the operation given by md_op this cycle.
- md_op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4-7 reserved.
- rs_data  in  32  operand A (forwarded rs).
- rt_data  in  32  operand B (forwarded rt).
- hiWE  in  1  mthi: write rs_data to HI.
- loWE  in  1  mtlo: write rs_data to LO.
- hisel  in  1  read select: 1=HI, 0=LO.
- busy  out  1  operation in flight.
- hi  out  32  current HI register.
- lo  out  32  current LO register.
- md_E_o  out  32  combinational: hisel ? hi : lo.

Behaviour:
- Reset (asynchronous, active-high, clk/reset as named above):
  - hi=0, lo=0, busy=0, counter=0, pending results=0.
  - Reset asserted mid-operation aborts it; no commit occurs.
- States: IDLE, RUN.
- IDLE, start=1, md_op in 0..3:
  - On that edge, latch computed results into hi_pend/lo_pend.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, md_op in 4..7: ignored, stay IDLE.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1: hi<=hi_pend, lo<=lo_pend, busy<=0, go to IDLE.
- Timing: start sampled in cycle N gives busy=1 in cycles N+1..N+C and new HI/LO visible in cycle N+C+1 (C = 5 or 10).
- Arithmetic:
  - mult: signed 32x32 to 64 bit; HI=[63:32], LO=[31:0].
  - multu: unsigned, same split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned.
- Divide by zero (rt_data==0, div or divu): busy sequence runs normally; HI/LO unchanged at commit.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Operands are sampled only on the start edge; later operand changes have no effect.
- hiWE/loWE:
  - In IDLE with start=0: write rs_data on the edge. hiWE and loWE together write both.
  - Ignored while busy=1 or start=1.
- start while busy=1: ignored; the hazard unit guarantees it cannot occur, and the bench checks it is harmless.
- md_E_o reflects committed HI/LO only; it never forwards pending results.

Decomposition:
- Shared package (alongside the Controller encodings):
  - md_op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3.
  - Default MULT_CYCLES and DIV_CYCLES.
- One natural sub-module, md_calc:
  - Combinational signed/unsigned product, quotient and remainder.
  - Outputs {hi_res, lo_res} and div_zero.
  - Keeps the arithmetic separable from the counter/FSM for unit testing.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3, start for 1 cycle -> busy=1 exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged while busy.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu same operands -> lo=0x7FFFFFFC, hi=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 -> hi/lo updated the next edge; hisel=1/0 gives md_E_o=0x12345678/0x9ABCDEF0. Then div rt=0 -> busy 10 cycles, hi/lo keep those values.
- Start mult (5x6); assert reset in the 3rd busy cycle -> busy=0, hi=lo=0 immediately (asynchronously); no commit of 30 afterwards.
- During a div, pulse start with mult and pulse hiWE -> both ignored; final lo/hi equal to the div result only.
